// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift arbiter slice:
//   - DATA_W / SHAMT_W : operand width and shift-amount width
//   - state_t          : FSM encoding used by shift_arbiter (IDLE/EXEC/RESP)
//   - cmd_t            : one captured command (operand, shift amount, direction)
//   - rr_pick()        : two-way round-robin grant decision
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        logic               lr;     // 0 = left, 1 = right
    } cmd_t;

    // With both requesters valid the one not served last wins; with only one
    // valid that one wins. The result is don't-care when nothing is valid.
    function automatic logic rr_pick(input logic [1:0] valid, input logic last);
        if (valid == 2'b11) begin
            return ~last;
        end
        return valid[1];
    endfunction

endpackage

// File: rtl/shift_core.sv
// -----------------------------------------------------------------------------
// shift_core
// Purely combinational logical shifter with zero fill.
// Built as a log2 barrel: stage k shifts by 2**k when bit k of the shift
// amount is set, in the direction selected by i_lr.
// Ports:
//   i_in       : operand
//   i_shift    : shift amount 0..2**SHAMT_W-1
//   i_lr       : 0 = shift left, 1 = shift right
//   o_data_out : shifted result
// -----------------------------------------------------------------------------
module shift_core
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  i_in,
    input  logic [SHAMT_W-1:0] i_shift,
    input  logic               i_lr,
    output logic [DATA_W-1:0]  o_data_out
);

    genvar gi;
    generate
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            logic [DATA_W-1:0] w_src;
            logic [DATA_W-1:0] w_out;

            if (gi == 0) begin : g_first
                assign w_src = i_in;
            end else begin : g_next
                assign w_src = g_stage[gi-1].w_out;
            end

            always_comb begin
                w_out = w_src;
                if (i_shift[gi]) begin
                    if (i_lr) begin
                        w_out = w_src >> STEP;
                    end else begin
                        w_out = w_src << STEP;
                    end
                end
            end
        end
    endgenerate

    assign o_data_out = g_stage[SHAMT_W-1].w_out;

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Two requesters share one shift unit. A round-robin arbiter grants one
// command at a time in IDLE; the command is captured, shifted in EXEC and the
// result is presented in RESP until the consumer takes it. Commands are never
// queued: a requester simply holds valid until it sees req_ready.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid[1:0]       : per-requester command valid
//   req_ready[1:0]       : per-requester command accepted this cycle (one-hot)
//   req{0,1}_in          : operand byte
//   req{0,1}_shift       : shift amount 0..7
//   req{0,1}_LR          : 0 = left, 1 = right
//   rsp_valid/rsp_ready  : result handshake
//   rsp_data             : shifted result
//   rsp_id               : requester that owns rsp_data
//   op_count             : completed operations, wraps 255 -> 0
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [DATA_W-1:0]   req0_in,
    input  logic [DATA_W-1:0]   req1_in,
    input  logic [SHAMT_W-1:0]  req0_shift,
    input  logic [SHAMT_W-1:0]  req1_shift,
    input  logic                req0_LR,
    input  logic                req1_LR,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_id,
    output logic [7:0]          op_count
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic               r_last;        // index served most recently
    cmd_t               r_cmd;         // command captured at acceptance
    logic               r_cmd_id;      // owner of r_cmd
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_id;
    logic [7:0]         r_op_count;

    // -------------------------------------------------------------------------
    // Arbitration and command select
    // -------------------------------------------------------------------------
    cmd_t               w_cmd [NREQ];
    cmd_t               w_sel_cmd;
    logic               w_grant;
    logic               w_accept;
    logic [NREQ-1:0]    w_ready;
    logic [DATA_W-1:0]  w_shifted;

    assign w_cmd[0] = '{data: req0_in, shamt: req0_shift, lr: req0_LR};
    assign w_cmd[1] = '{data: req1_in, shamt: req1_shift, lr: req1_LR};

    assign w_grant   = rr_pick(req_valid, r_last);
    assign w_sel_cmd = w_cmd[w_grant];

    // Ready is combinational so a command is taken in the same cycle it is
    // offered; rst gates it so nothing is acknowledged while being cleared.
    assign w_accept = (r_state == IDLE) && !rst && req_valid[w_grant];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign w_ready[gi] = w_accept && (w_grant == gi[0]);
        end
    endgenerate

    assign req_ready = w_ready;

    // -------------------------------------------------------------------------
    // Shift datapath, fed only from the captured command so the requester is
    // free to change its inputs once accepted.
    // -------------------------------------------------------------------------
    shift_core u_shift_core (
        .i_in       (r_cmd.data),
        .i_shift    (r_cmd.shamt),
        .i_lr       (r_cmd.lr),
        .o_data_out (w_shifted)
    );

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;       // requester 0 wins the first tie
            r_cmd       <= '0;
            r_cmd_id    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cmd    <= w_sel_cmd;
                        r_cmd_id <= w_grant;
                        r_last   <= w_grant;
                        r_state  <= EXEC;
                    end
                end

                EXEC: begin
                    r_rsp_data  <= w_shifted;
                    r_rsp_id    <= r_cmd_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end

                RESP: begin
                    // rsp_ready only matters here; data and id stay frozen
                    // until the consumer takes them.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 8'd1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;

endmodule
